// File: rtl/fdtd_calc_seq_if.sv
// Register bus for the FDTD calculation sequencer: a single-cycle write port
// with byte strobes and a combinational read port.
interface fdtd_calc_seq_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int WORD_ADDR_WIDTH = 8
);
    logic                         wr_valid_i;
    logic [WORD_ADDR_WIDTH-1:0]   wr_addr_i;
    logic [DATA_WIDTH-1:0]        wr_data_i;
    logic [DATA_WIDTH/8-1:0]      wr_strb_i;
    logic [WORD_ADDR_WIDTH-1:0]   rd_addr_i;
    logic [DATA_WIDTH-1:0]        rd_data_o;

    modport master (
        output wr_valid_i, wr_addr_i, wr_data_i, wr_strb_i, rd_addr_i,
        input  rd_data_o
    );

    modport slave (
        input  wr_valid_i, wr_addr_i, wr_data_i, wr_strb_i, rd_addr_i,
        output rd_data_o
    );
endinterface

// File: rtl/fdtd_calc_seq.sv
// FDTD calculation sequencer: walks N_STAGE calc stages for ITER iterations,
// pulsing each unmasked stage and waiting for its done flag.
// Optional WAIT watchdog enabled by defining FDTD_SEQ_TIMEOUT_EN.
// DATA_WIDTH must be at least 16 (CTRL uses bytes 0 and 1).
//
// state | meaning
// IDLE  | waiting for CMD.start
// START | one-cycle start pulse on stage cur_stage
// WAIT  | waiting for stage_done_i[cur_stage]
// NEXT  | advance to next stage / iteration (also the cost of a masked stage)
// DONE  | sequence complete, raise int_pending
module fdtd_calc_seq #(
    parameter int DATA_WIDTH      = 32,
    parameter int N_STAGE         = 3,
    parameter int ITER_WIDTH      = 16,
    parameter int WORD_ADDR_WIDTH = 8
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    fdtd_calc_seq_if.slave       bus,
    output logic [N_STAGE-1:0]   stage_start_o,
    input  logic [N_STAGE-1:0]   stage_done_i,
    output logic                 busy_o,
    output logic                 irq_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_NEXT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [WORD_ADDR_WIDTH-1:0] A_CTRL      = WORD_ADDR_WIDTH'(0);
    localparam logic [WORD_ADDR_WIDTH-1:0] A_ITER      = WORD_ADDR_WIDTH'(1);
    localparam logic [WORD_ADDR_WIDTH-1:0] A_CMD       = WORD_ADDR_WIDTH'(2);
    localparam logic [WORD_ADDR_WIDTH-1:0] A_STATUS    = WORD_ADDR_WIDTH'(3);
    localparam logic [WORD_ADDR_WIDTH-1:0] A_ITER_DONE = WORD_ADDR_WIDTH'(4);
    localparam logic [WORD_ADDR_WIDTH-1:0] A_CUR_STAGE = WORD_ADDR_WIDTH'(5);
`ifdef FDTD_SEQ_TIMEOUT_EN
    localparam logic [WORD_ADDR_WIDTH-1:0] A_TIMEOUT   = WORD_ADDR_WIDTH'(6);
`endif

    localparam logic [2:0] LAST_STAGE = 3'(N_STAGE - 1);

    logic [2:0]            state_q, state_d;
    logic [2:0]            cur_stage_q, cur_stage_d;
    logic [ITER_WIDTH-1:0] iter_done_q, iter_done_d;
    logic [ITER_WIDTH-1:0] iter_q, iter_d;
    logic [ITER_WIDTH-1:0] iter_inc;
    logic [N_STAGE-1:0]    mask_q, mask_d;
    logic                  int_en_q, int_en_d;
    logic                  int_pending_q, int_pending_d;
    logic                  aborted_q, aborted_d;
    logic                  to_flag_q, to_flag_d;
    logic                  int_set;
`ifdef FDTD_SEQ_TIMEOUT_EN
    logic [DATA_WIDTH-1:0] tmo_val_q, tmo_val_d;
    logic [DATA_WIDTH-1:0] wdog_q, wdog_d;
`endif

    logic cmd_wr, start_cmd, abort_cmd, clr_cmd, cfg_wr_ok;
    logic unused_bus_bits;

    // Select bit idx of a per-stage vector without an over-wide index.
    function automatic logic bit_at(input logic [N_STAGE-1:0] v, input logic [2:0] idx);
        logic r;
        r = 1'b0;
        for (int k = 0; k < N_STAGE; k++) begin
            if (idx == 3'(k)) r = v[k];
        end
        return r;
    endfunction

    assign busy_o    = (state_q != S_IDLE);
    assign irq_o     = int_pending_q & int_en_q;
    assign cmd_wr    = bus.wr_valid_i && (bus.wr_addr_i == A_CMD);
    assign start_cmd = cmd_wr & bus.wr_data_i[0];
    assign abort_cmd = cmd_wr & bus.wr_data_i[1];
    assign clr_cmd   = cmd_wr & bus.wr_data_i[2];
    assign cfg_wr_ok = bus.wr_valid_i & ~busy_o;
    assign iter_inc  = iter_done_q + ITER_WIDTH'(1);
    assign unused_bus_bits = ^{bus.wr_data_i, bus.wr_strb_i};

    // One-hot start pulse for the current stage while in START.
    always_comb begin
        stage_start_o = '0;
        if (state_q == S_START) begin
            for (int k = 0; k < N_STAGE; k++) begin
                if (cur_stage_q == 3'(k)) stage_start_o[k] = 1'b1;
            end
        end
    end

    // Configuration register writes; CTRL/ITER frozen while a sequence runs.
    always_comb begin
        int_en_d = int_en_q;
        mask_d   = mask_q;
        iter_d   = iter_q;
        if (cfg_wr_ok && bus.wr_addr_i == A_CTRL) begin
            if (bus.wr_strb_i[0]) int_en_d = bus.wr_data_i[0];
            if (bus.wr_strb_i[1]) mask_d   = bus.wr_data_i[8 +: N_STAGE];
        end
        if (cfg_wr_ok && bus.wr_addr_i == A_ITER) begin
            for (int i = 0; i < ITER_WIDTH; i++) begin
                if (bus.wr_strb_i[i/8]) iter_d[i] = bus.wr_data_i[i];
            end
        end
    end

`ifdef FDTD_SEQ_TIMEOUT_EN
    // Watchdog limit register and WAIT down-counter (loaded in START).
    always_comb begin
        tmo_val_d = tmo_val_q;
        if (bus.wr_valid_i && bus.wr_addr_i == A_TIMEOUT) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (bus.wr_strb_i[i/8]) tmo_val_d[i] = bus.wr_data_i[i];
            end
        end
        wdog_d = wdog_q;
        if (state_q == S_START) begin
            wdog_d = tmo_val_q - DATA_WIDTH'(1);
        end else if (state_q == S_WAIT && wdog_q != '0) begin
            wdog_d = wdog_q - DATA_WIDTH'(1);
        end
    end
`endif

    // Sequencer next-state, stage/iteration bookkeeping and status flags.
    always_comb begin
        state_d     = state_q;
        cur_stage_d = cur_stage_q;
        iter_done_d = iter_done_q;
        aborted_d   = aborted_q;
        to_flag_d   = to_flag_q;
        int_set     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_cmd) begin
                    aborted_d   = 1'b0;
                    to_flag_d   = 1'b0;
                    iter_done_d = '0;
                    cur_stage_d = 3'd0;
                    if (iter_q == '0)                state_d = S_DONE;
                    else if (bit_at(mask_q, 3'd0))   state_d = S_START;
                    else                             state_d = S_NEXT;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (bit_at(stage_done_i, cur_stage_q)) begin
                    state_d = S_NEXT;
                end
`ifdef FDTD_SEQ_TIMEOUT_EN
                else if (tmo_val_q != '0 && wdog_q == '0) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                    to_flag_d = 1'b1;
                    int_set   = 1'b1;
                end
`endif
            end
            S_NEXT: begin
                if (cur_stage_q == LAST_STAGE) begin
                    iter_done_d = iter_inc;
                    cur_stage_d = 3'd0;
                    if (iter_inc == iter_q)          state_d = S_DONE;
                    else if (bit_at(mask_q, 3'd0))   state_d = S_START;
                    else                             state_d = S_NEXT;
                end else begin
                    cur_stage_d = cur_stage_q + 3'd1;
                    state_d = bit_at(mask_q, cur_stage_q + 3'd1) ? S_START : S_NEXT;
                end
            end
            S_DONE: begin
                int_set = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Host abort wins over any in-flight progress this cycle.
        if (busy_o && abort_cmd) begin
            state_d     = S_IDLE;
            aborted_d   = 1'b1;
            int_set     = 1'b1;
            iter_done_d = iter_done_q;
            cur_stage_d = cur_stage_q;
        end
    end

    // Setting int_pending has priority over a simultaneous clr_int.
    always_comb begin
        if (int_set)      int_pending_d = 1'b1;
        else if (clr_cmd) int_pending_d = 1'b0;
        else              int_pending_d = int_pending_q;
    end

    // Combinational register read mux; unmapped and write-only read as 0.
    always_comb begin
        bus.rd_data_o = '0;
        case (bus.rd_addr_i)
            A_CTRL: begin
                bus.rd_data_o[0]           = int_en_q;
                bus.rd_data_o[8 +: N_STAGE] = mask_q;
            end
            A_ITER:      bus.rd_data_o = DATA_WIDTH'(iter_q);
            A_STATUS:    bus.rd_data_o = DATA_WIDTH'({to_flag_q, aborted_q, int_pending_q, busy_o});
            A_ITER_DONE: bus.rd_data_o = DATA_WIDTH'(iter_done_q);
            A_CUR_STAGE: bus.rd_data_o = DATA_WIDTH'(cur_stage_q);
`ifdef FDTD_SEQ_TIMEOUT_EN
            A_TIMEOUT:   bus.rd_data_o = tmo_val_q;
`endif
            default:     bus.rd_data_o = '0;
        endcase
    end

    // State and register update with asynchronous active-low clear.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q       <= S_IDLE;
            cur_stage_q   <= 3'd0;
            iter_done_q   <= '0;
            iter_q        <= '0;
            mask_q        <= '0;
            int_en_q      <= 1'b0;
            int_pending_q <= 1'b0;
            aborted_q     <= 1'b0;
            to_flag_q     <= 1'b0;
`ifdef FDTD_SEQ_TIMEOUT_EN
            tmo_val_q     <= '0;
            wdog_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cur_stage_q   <= cur_stage_d;
            iter_done_q   <= iter_done_d;
            iter_q        <= iter_d;
            mask_q        <= mask_d;
            int_en_q      <= int_en_d;
            int_pending_q <= int_pending_d;
            aborted_q     <= aborted_d;
            to_flag_q     <= to_flag_d;
`ifdef FDTD_SEQ_TIMEOUT_EN
            tmo_val_q     <= tmo_val_d;
            wdog_q        <= wdog_d;
`endif
        end
    end

endmodule

// File: tb/tb_fdtd_calc_seq.sv
// Directed bench for fdtd_calc_seq (default parameters). A background
// responder raises stage_done_i 4 cycles after each start pulse while enabled.
module tb_fdtd_calc_seq;
    localparam int DW = 32;
    localparam int NS = 3;
    localparam int IW = 16;
    localparam int AW = 8;

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic [NS-1:0] stage_start_o;
    logic [NS-1:0] stage_done_i;
    logic          busy_o, irq_o;

    fdtd_calc_seq_if #(.DATA_WIDTH(DW), .WORD_ADDR_WIDTH(AW)) bus ();

    fdtd_calc_seq #(.DATA_WIDTH(DW), .N_STAGE(NS), .ITER_WIDTH(IW), .WORD_ADDR_WIDTH(AW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .bus(bus),
        .stage_start_o(stage_start_o), .stage_done_i(stage_done_i),
        .busy_o(busy_o), .irq_o(irq_o)
    );

    always #5 ACLK = ~ACLK;

    int vectors = 0;
    int miscompares = 0;
    int pulses[$];
    int busy_cycles = 0;
    bit resp_en = 1'b0;
    int cnt[NS];
    int idx;

    // Pulse logger, busy-cycle counter and stage_done responder.
    initial begin
        stage_done_i = '0;
        for (int k = 0; k < NS; k++) cnt[k] = 0;
        forever begin
            @(negedge ACLK);
            if (busy_o) busy_cycles++;
            if (stage_start_o != '0) begin
                idx = 99;
                if ($onehot(stage_start_o))
                    for (int k = 0; k < NS; k++) if (stage_start_o[k]) idx = k;
                pulses.push_back(idx);
            end
            stage_done_i = '0;
            for (int k = 0; k < NS; k++) begin
                if (!resp_en || !ARESETn) cnt[k] = 0;
                else begin
                    if (cnt[k] > 0) begin
                        cnt[k]--;
                        if (cnt[k] == 0) stage_done_i[k] = 1'b1;
                    end
                    if (stage_start_o[k]) cnt[k] = 4;
                end
            end
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.wr_valid_i = 1'b1;
        bus.wr_addr_i  = a;
        bus.wr_data_i  = d;
        bus.wr_strb_i  = s;
        tick();
        bus.wr_valid_i = 1'b0;
        bus.wr_strb_i  = '0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        bus.rd_addr_i = a;
        #1;
        d = bus.rd_data_o;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy_o && n < budget) begin
            tick();
            n++;
        end
        vectors++;
        if (busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_idle: busy_o=%0b after %0d cycles, want 0", busy_o, budget);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        bus.wr_valid_i = 1'b0; bus.wr_addr_i = '0; bus.wr_data_i = '0;
        bus.wr_strb_i = '0; bus.rd_addr_i = '0;
        repeat (2) @(posedge ACLK);
        #1;
        vectors++; if ({busy_o, irq_o, stage_start_o} !== 5'b0) begin miscompares++;
            $display("FAIL reset_outputs: got %b want 00000", {busy_o, irq_o, stage_start_o}); end
        ARESETn = 1'b1;
        tick();
        for (int a = 0; a < 8; a++) begin
            rd(8'(a), d);
            vectors++; if (d !== 32'h0) begin miscompares++;
                $display("FAIL reset_reg%0d: got %h want 0", a, d); end
        end
    endtask

    task automatic test_strobes();
        logic [31:0] d;
        wr(8'h00, 32'h0000_0701, 4'hF);
        wr(8'h00, 32'h0000_0000, 4'b0010);
        rd(8'h00, d);
        vectors++; if (d !== 32'h0000_0001) begin miscompares++;
            $display("FAIL strb_ctrl: got %h want 00000001", d); end
        wr(8'h01, 32'h0000_1234, 4'hF);
        wr(8'h01, 32'h0000_ABCD, 4'b0001);
        wr(8'h01, 32'hFFFF_0000, 4'b1100);
        rd(8'h01, d);
        vectors++; if (d !== 32'h0000_12CD) begin miscompares++;
            $display("FAIL strb_iter: got %h want 000012cd", d); end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        int exp_p[6] = '{0, 1, 2, 0, 1, 2};
        wr(8'h00, 32'h0000_0701, 4'hF);
        wr(8'h01, 32'h0000_0002, 4'hF);
        rd(8'h00, d);
        vectors++; if (d !== 32'h701) begin miscompares++; $display("FAIL basic_ctrl: got %h want 701", d); end
        pulses.delete(); resp_en = 1'b1; busy_cycles = 0;
        wr(8'h02, 32'h1, 4'hF);
        vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL basic_busy: got %b want 1", busy_o); end
        wait_idle(200);
        vectors++;
        if (pulses.size() != 6) begin miscompares++; $display("FAIL basic_npulse: got %0d want 6", pulses.size()); end
        else for (int i = 0; i < 6; i++) begin
            vectors++; if (pulses[i] != exp_p[i]) begin miscompares++;
                $display("FAIL basic_pulse%0d: got %0d want %0d", i, pulses[i], exp_p[i]); end
        end
        vectors++; if (busy_cycles != 37) begin miscompares++; $display("FAIL basic_cycles: got %0d want 37", busy_cycles); end
        rd(8'h04, d);
        vectors++; if (d !== 32'h2) begin miscompares++; $display("FAIL basic_iter_done: got %h want 2", d); end
        rd(8'h03, d);
        vectors++; if (d !== 32'h2) begin miscompares++; $display("FAIL basic_status: got %h want 2", d); end
        vectors++; if (irq_o !== 1'b1) begin miscompares++; $display("FAIL basic_irq: got %b want 1", irq_o); end
        rd(8'h05, d);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL basic_cur_stage: got %h want 0", d); end
        wr(8'h02, 32'h4, 4'hF);
        rd(8'h03, d);
        vectors++; if (d !== 32'h0 || irq_o !== 1'b0) begin miscompares++;
            $display("FAIL basic_clr: status %h irq %b want 0 0", d, irq_o); end
    endtask

    task automatic test_mask();
        logic [31:0] d;
        wr(8'h00, 32'h0000_0501, 4'hF);
        wr(8'h01, 32'h1, 4'hF);
        pulses.delete(); resp_en = 1'b1; busy_cycles = 0;
        wr(8'h02, 32'h1, 4'hF);
        wait_idle(100);
        vectors++;
        if (pulses.size() != 2) begin miscompares++; $display("FAIL mask_npulse: got %0d want 2", pulses.size()); end
        else begin
            vectors++; if (pulses[0] != 0 || pulses[1] != 2) begin miscompares++;
                $display("FAIL mask_order: got %0d,%0d want 0,2", pulses[0], pulses[1]); end
        end
        vectors++; if (busy_cycles != 14) begin miscompares++; $display("FAIL mask_cycles: got %0d want 14", busy_cycles); end
        rd(8'h04, d);
        vectors++; if (d !== 32'h1) begin miscompares++; $display("FAIL mask_iter_done: got %h want 1", d); end
        wr(8'h02, 32'h4, 4'hF);
        wr(8'h00, 32'h0000_0001, 4'hF);
        wr(8'h01, 32'h2, 4'hF);
        pulses.delete(); busy_cycles = 0;
        wr(8'h02, 32'h1, 4'hF);
        wait_idle(100);
        vectors++; if (busy_cycles != 7 || pulses.size() != 0) begin miscompares++;
            $display("FAIL allmask: cycles %0d pulses %0d want 7 0", busy_cycles, pulses.size()); end
        rd(8'h04, d);
        vectors++; if (d !== 32'h2) begin miscompares++; $display("FAIL allmask_iter_done: got %h want 2", d); end
        wr(8'h02, 32'h4, 4'hF);
    endtask

    task automatic test_zero_iter();
        logic [31:0] d;
        wr(8'h00, 32'h0000_0701, 4'hF);
        wr(8'h01, 32'h0, 4'hF);
        pulses.delete(); busy_cycles = 0;
        wr(8'h02, 32'h1, 4'hF);
        vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL zero_busy: got %b want 1", busy_o); end
        tick();
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL zero_idle: got %b want 0", busy_o); end
        vectors++; if (busy_cycles != 1 || pulses.size() != 0) begin miscompares++;
            $display("FAIL zero_run: cycles %0d pulses %0d want 1 0", busy_cycles, pulses.size()); end
        rd(8'h03, d);
        vectors++; if (d !== 32'h2) begin miscompares++; $display("FAIL zero_status: got %h want 2", d); end
        wr(8'h02, 32'h4, 4'hF);
        wr(8'h02, 32'h1, 4'hF);
        wr(8'h02, 32'h4, 4'hF);
        rd(8'h03, d);
        vectors++; if (d !== 32'h2) begin miscompares++; $display("FAIL clr_priority: got %h want 2", d); end
        wr(8'h02, 32'h4, 4'hF);
        rd(8'h03, d);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL clr_after: got %h want 0", d); end
    endtask

    task automatic test_abort();
        logic [31:0] d;
        int n;
        wr(8'h00, 32'h0000_0701, 4'hF);
        wr(8'h01, 32'h2, 4'hF);
        pulses.delete(); resp_en = 1'b1;
        wr(8'h02, 32'h1, 4'hF);
        n = 0;
        while (pulses.size() < 5 && n < 200) begin tick(); n++; end
        resp_en = 1'b0;
        vectors++; if (pulses.size() < 5) begin miscompares++;
            $display("FAIL abort_reach: pulses %0d want 5", pulses.size()); end
        tick(); tick();
        rd(8'h05, d);
        vectors++; if (d !== 32'h1 || busy_o !== 1'b1) begin miscompares++;
            $display("FAIL abort_wait: stage %h busy %b want 1 1", d, busy_o); end
        wr(8'h00, 32'h0, 4'hF);
        wr(8'h01, 32'h5, 4'hF);
        rd(8'h00, d);
        vectors++; if (d !== 32'h701) begin miscompares++; $display("FAIL busy_ctrl_wr: got %h want 701", d); end
        rd(8'h01, d);
        vectors++; if (d !== 32'h2) begin miscompares++; $display("FAIL busy_iter_wr: got %h want 2", d); end
        wr(8'h02, 32'h1, 4'hF);
        rd(8'h04, d);
        vectors++; if (d !== 32'h1 || stage_start_o !== 3'b0) begin miscompares++;
            $display("FAIL busy_start: iter_done %h start %b want 1 000", d, stage_start_o); end
        wr(8'h02, 32'h2, 4'hF);
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL abort_idle: got %b want 0", busy_o); end
        rd(8'h03, d);
        vectors++; if (d !== 32'h6) begin miscompares++; $display("FAIL abort_status: got %h want 6", d); end
        rd(8'h04, d);
        vectors++; if (d !== 32'h1) begin miscompares++; $display("FAIL abort_iter_done: got %h want 1", d); end
        vectors++; if (irq_o !== 1'b1) begin miscompares++; $display("FAIL abort_irq: got %b want 1", irq_o); end
        wr(8'h02, 32'h4, 4'hF);
        wr(8'h02, 32'h2, 4'hF);
        rd(8'h03, d);
        vectors++; if (d !== 32'h4) begin miscompares++; $display("FAIL abort_in_idle: got %h want 4", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int exp_p[6] = '{0, 1, 2, 0, 1, 2};
        resp_en = 1'b0;
        wr(8'h00, 32'h0000_0701, 4'hF);
        wr(8'h01, 32'h2, 4'hF);
        wr(8'h02, 32'h1, 4'hF);
        tick(); tick(); tick();
        #2 ARESETn = 1'b0;
        #1;
        vectors++; if ({busy_o, irq_o, stage_start_o} !== 5'b0) begin miscompares++;
            $display("FAIL rstmid_outputs: got %b want 00000", {busy_o, irq_o, stage_start_o}); end
        rd(8'h00, d);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL rstmid_ctrl: got %h want 0", d); end
        rd(8'h03, d);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL rstmid_status: got %h want 0", d); end
        ARESETn = 1'b1;
        tick();
        wr(8'h00, 32'h0000_0701, 4'hF);
        wr(8'h01, 32'h2, 4'hF);
        pulses.delete(); resp_en = 1'b1; busy_cycles = 0;
        wr(8'h02, 32'h1, 4'hF);
        wait_idle(200);
        vectors++;
        if (pulses.size() != 6) begin miscompares++; $display("FAIL rstmid_npulse: got %0d want 6", pulses.size()); end
        else for (int i = 0; i < 6; i++) begin
            vectors++; if (pulses[i] != exp_p[i]) begin miscompares++;
                $display("FAIL rstmid_pulse%0d: got %0d want %0d", i, pulses[i], exp_p[i]); end
        end
        vectors++; if (busy_cycles != 37) begin miscompares++; $display("FAIL rstmid_cycles: got %0d want 37", busy_cycles); end
        rd(8'h04, d);
        vectors++; if (d !== 32'h2 || irq_o !== 1'b1) begin miscompares++;
            $display("FAIL rstmid_done: iter_done %h irq %b want 2 1", d, irq_o); end
        wr(8'h02, 32'h4, 4'hF);
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        resp_en = 1'b0;
        wr(8'h00, 32'h0000_0701, 4'hF);
        wr(8'h01, 32'h1, 4'hF);
        wr(8'h06, 32'd10, 4'hF);
`ifdef FDTD_SEQ_TIMEOUT_EN
        rd(8'h06, d);
        vectors++; if (d !== 32'd10) begin miscompares++; $display("FAIL tmo_reg: got %h want 0000000a", d); end
        pulses.delete(); busy_cycles = 0;
        wr(8'h02, 32'h1, 4'hF);
        wait_idle(100);
        vectors++; if (busy_cycles != 11) begin miscompares++; $display("FAIL tmo_cycles: got %0d want 11", busy_cycles); end
        rd(8'h03, d);
        vectors++; if (d !== 32'hE) begin miscompares++; $display("FAIL tmo_status: got %h want e", d); end
        wr(8'h06, 32'd0, 4'hF);
`else
        rd(8'h06, d);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL tmo_reg_absent: got %h want 0", d); end
        wr(8'h02, 32'h1, 4'hF);
        repeat (40) tick();
        rd(8'h03, d);
        vectors++; if (d !== 32'h1) begin miscompares++; $display("FAIL no_watchdog: got %h want 1", d); end
        wr(8'h02, 32'h2, 4'hF);
        rd(8'h03, d);
        vectors++; if (d !== 32'h6) begin miscompares++; $display("FAIL no_wdog_abort: got %h want 6", d); end
`endif
        wr(8'h02, 32'h4, 4'hF);
    endtask

    initial begin
        test_reset();
        test_strobes();
        test_basic();
        test_mask();
        test_zero_iter();
        test_abort();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/fdtd_calc_seq.md
FDTD_CALC_SEQ -- requirements
Module: fdtd_calc_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter N_STAGE, default 3, number of calc stages (1..8).
REQ-003 SHALL have parameter ITER_WIDTH, default 16, iteration counter width (<= DATA_WIDTH).
REQ-004 SHALL have parameter WORD_ADDR_WIDTH, default 8, register word-address width.
REQ-005 SHALL have one clock and an asynchronous, active-low reset.
REQ-006 SHALL have port ACLK, input, 1, clock.
REQ-007 SHALL have port ARESETn, input, 1, async active-low reset.
REQ-008 SHALL have port wr_valid_i, input, 1, register write strobe.
REQ-009 SHALL have port wr_addr_i, input, WORD_ADDR_WIDTH, write word address.
REQ-010 SHALL have port wr_data_i, input, DATA_WIDTH, write data.
REQ-011 SHALL have port wr_strb_i, input, DATA_WIDTH/8, byte strobes.
REQ-012 SHALL have port rd_addr_i, input, WORD_ADDR_WIDTH, read word address.
REQ-013 SHALL have port rd_data_o, output, DATA_WIDTH, combinational read data.
REQ-014 SHALL have port stage_start_o, output, N_STAGE, one-cycle start pulse per stage.
REQ-015 SHALL have port stage_done_i, input, N_STAGE, stage completion flag (sampled high).
REQ-016 SHALL have port busy_o, output, 1, sequence running.
REQ-017 SHALL have port irq_o, output, 1, int_pending AND int_en.

Function
REQ-018 SHALL map registers: 0x00 CTRL (bit0 int_en, bits[8+N_STAGE-1:8] stage_mask), 0x01 ITER (ITER_WIDTH), 0x02 CMD (bit0 start, bit1 abort, bit2 clr_int; write-only, reads 0), 0x03 STATUS (bit0 busy, bit1 int_pending, bit2 aborted, bit3 timeout), 0x04 ITER_DONE (RO), 0x05 CUR_STAGE (RO); unmapped reads 0; byte strobes honoured on CTRL/ITER.
REQ-019 SHALL ignore writes to CTRL and ITER while busy.
REQ-020 SHALL implement FSM IDLE -> START -> WAIT -> NEXT -> (START | DONE) -> IDLE.
REQ-021 SHALL, on CMD.start written at cycle t in IDLE, clear aborted/timeout and ITER_DONE, set cur_stage=0, enter START at t+1 (NEXT at t+1 if stage 0 masked); start while busy ignored.
REQ-022 SHALL assert stage_start_o[cur_stage] for exactly the one cycle spent in START, then enter WAIT.
REQ-023 SHALL leave WAIT for NEXT the cycle after stage_done_i[cur_stage] is sampled high; done on other bits ignored.
REQ-024 SHALL in NEXT advance cur_stage; a masked stage costs one NEXT cycle, no pulse; after stage N_STAGE-1, increment ITER_DONE, wrap cur_stage to 0, go DONE if ITER_DONE==ITER else continue.
REQ-025 SHALL with ITER=0 go IDLE->DONE with no pulses; with all stages masked run ITER iterations of N_STAGE NEXT cycles each.
REQ-026 SHALL in DONE set int_pending for one cycle, then IDLE; busy_o high in all states except IDLE.
REQ-027 SHALL on CMD.abort while busy return to IDLE next cycle, set aborted and int_pending; abort in IDLE ignored.
REQ-028 SHALL give int_pending set priority over simultaneous clr_int.

Reset
REQ-029 SHALL on ARESETn low force IDLE, all registers, counters, stage_start_o, busy_o, irq_o to 0, including mid-sequence.

Configuration
REQ-030 SHALL with FDTD_SEQ_TIMEOUT_EN defined add register 0x06 TIMEOUT (DATA_WIDTH, 0 = disabled) and a WAIT-cycle counter; counter reaching TIMEOUT aborts as REQ-027 plus sets timeout.
REQ-031 SHALL without FDTD_SEQ_TIMEOUT_EN read 0x06 as 0, hold timeout at 0, never abort by watchdog.

Verification
REQ-032 SHALL test N_STAGE=3, mask=0b111, ITER=2, done 4 cycles after each pulse -> 6 pulses in order 0,1,2,0,1,2; ITER_DONE=2; irq_o=1 with int_en.
REQ-033 SHALL test mask=0b101, ITER=1 -> pulses on stages 0,2 only; stage 1 costs one cycle.
REQ-034 SHALL test ITER=0, start -> no pulses, busy one cycle, int_pending=1.
REQ-035 SHALL test abort during WAIT of stage 1 -> IDLE next cycle, STATUS=0b0110, ITER_DONE unchanged.
REQ-036 SHALL test ARESETn low during WAIT -> all outputs 0 immediately; new start behaves as REQ-032.
REQ-037 SHALL test with FDTD_SEQ_TIMEOUT_EN, TIMEOUT=10, done never asserted -> abort after 10 WAIT cycles, STATUS bit3=1.
